// File: rtl/relay_alu_pkg.sv
// Shared types for the relay logic unit controller: op codes, sequencer states
// and the op -> one-hot function-enable mapping.
package relay_alu_pkg;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOT = 2'b11
  } logic_op_e;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    DRIVE,
    RESP
  } seq_state_e;

  localparam logic [3:0] FN_NONE = 4'b0000;

  // fn_sel bit order is {NOT,XOR,OR,AND}
  function automatic logic [3:0] op_to_fnsel(input logic_op_e op);
    logic [3:0] fn;
    fn = FN_NONE;
    case (op)
      OP_AND:  fn = 4'b0001;
      OP_OR:   fn = 4'b0010;
      OP_XOR:  fn = 4'b0100;
      OP_NOT:  fn = 4'b1000;
      default: fn = FN_NONE;
    endcase
    return fn;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/relay_delay_counter.sv
// Saturating up-counter shared by the settle and drive phases; start clears it,
// done flags the last enabled cycle of a tc-cycle interval.
module relay_delay_counter #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          en,
  input  logic [CW-1:0] tc,
  output logic          done
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (start) begin
      count_d = '0;
    end else if (en && (count_q < tc)) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = en && (count_q == (tc - CW'(1)));

endmodule

// File: rtl/relay_logic_sequencer.sv
// Sequencer for the relay logic unit: load operands, wait for relays to settle,
// drive fn_sel, sample the result and hand it back. Flags built only with LOGIC_FLAGS_EN.
module relay_logic_sequencer
  import relay_alu_pkg::*;
#(
  parameter int W             = 8,
  parameter int SETTLE_CYCLES = 3,
  parameter int DRIVE_CYCLES  = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [1:0]   req_op,
  input  logic [W-1:0] req_b,
  input  logic [W-1:0] req_c,
  output logic         ld_b,
  output logic         ld_c,
  output logic [W-1:0] opnd_b,
  output logic [W-1:0] opnd_c,
  output logic [3:0]   fn_sel,
  input  logic [W-1:0] gate_res,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_data,
  output logic         rsp_zero,
  output logic         rsp_sign,
  output logic         busy
);

  localparam int CW = $clog2(max2(SETTLE_CYCLES, DRIVE_CYCLES) + 1);
  localparam logic [CW-1:0] SETTLE_TC = CW'(SETTLE_CYCLES);
  localparam logic [CW-1:0] DRIVE_TC  = CW'(DRIVE_CYCLES);

  seq_state_e    state_q, state_d;
  logic_op_e     op_q, op_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  c_q, c_d;
  logic [W-1:0]  rsp_data_q, rsp_data_d;
  logic          cnt_start;
  logic          cnt_en;
  logic          cnt_done;
  logic [CW-1:0] cnt_tc;
  logic          sample;

  relay_delay_counter #(.CW(CW)) u_delay (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (cnt_start),
    .en      (cnt_en),
    .tc      (cnt_tc),
    .done    (cnt_done)
  );

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // rsp_valid stays high and rsp_data stays stable until that transfer.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    b_d        = b_q;
    c_d        = c_q;
    rsp_data_d = rsp_data_q;
    cnt_start  = 1'b0;
    cnt_en     = 1'b0;
    cnt_tc     = SETTLE_TC;
    sample     = 1'b0;
    req_ready  = 1'b0;
    ld_b       = 1'b0;
    ld_c       = 1'b0;
    opnd_b     = '0;
    opnd_c     = '0;
    fn_sel     = FN_NONE;
    rsp_valid  = 1'b0;
    rsp_data   = '0;
    busy       = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          op_d    = logic_op_e'(req_op);
          b_d     = req_b;
          c_d     = req_c;
          state_d = LOAD;
        end
      end
      LOAD: begin
        ld_b      = 1'b1;
        ld_c      = (op_q != OP_NOT);
        opnd_b    = b_q;
        opnd_c    = c_q;
        cnt_start = 1'b1;
        state_d   = SETTLE;
      end
      SETTLE: begin
        cnt_en = 1'b1;
        if (cnt_done) begin
          cnt_start = 1'b1;
          state_d   = DRIVE;
        end
      end
      DRIVE: begin
        cnt_en = 1'b1;
        cnt_tc = DRIVE_TC;
        fn_sel = op_to_fnsel(op_q);
        if (cnt_done) begin
          sample     = 1'b1;
          rsp_data_d = gate_res;
          state_d    = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_data  = rsp_data_q;
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      op_q       <= OP_AND;
      b_q        <= '0;
      c_q        <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      b_q        <= b_d;
      c_q        <= c_d;
      rsp_data_q <= rsp_data_d;
    end
  end

`ifdef LOGIC_FLAGS_EN
  logic zero_q, zero_d;
  logic sign_q, sign_d;

  always_comb begin
    zero_d = zero_q;
    sign_d = sign_q;
    if (sample) begin
      zero_d = (gate_res == '0);
      sign_d = gate_res[W-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      zero_q <= 1'b0;
      sign_q <= 1'b0;
    end else begin
      zero_q <= zero_d;
      sign_q <= sign_d;
    end
  end

  assign rsp_zero = rsp_valid & zero_q;
  assign rsp_sign = rsp_valid & sign_q;
`else
  assign rsp_zero = 1'b0;
  assign rsp_sign = 1'b0;
`endif

endmodule

// File: tb/tb_relay_logic_sequencer.sv
// Directed + randomized bench for relay_logic_sequencer with a behavioural relay logic unit.
module tb_relay_logic_sequencer;

  localparam int W  = 8;
  localparam int SC = 3;
  localparam int DC = 2;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [1:0]   req_op = 2'b00;
  logic [W-1:0] req_b = '0;
  logic [W-1:0] req_c = '0;
  logic         ld_b;
  logic         ld_c;
  logic [W-1:0] opnd_b;
  logic [W-1:0] opnd_c;
  logic [3:0]   fn_sel;
  logic [W-1:0] gate_res;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_data;
  logic         rsp_zero;
  logic         rsp_sign;
  logic         busy;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] unit_b = '0;
  logic [W-1:0] unit_c = '0;

  relay_logic_sequencer #(.W(W), .SETTLE_CYCLES(SC), .DRIVE_CYCLES(DC)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_b     (req_b),
    .req_c     (req_c),
    .ld_b      (ld_b),
    .ld_c      (ld_c),
    .opnd_b    (opnd_b),
    .opnd_c    (opnd_c),
    .fn_sel    (fn_sel),
    .gate_res  (gate_res),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_zero  (rsp_zero),
    .rsp_sign  (rsp_sign),
    .busy      (busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  // relay logic unit: operand registers plus gates enabled by fn_sel
  always @(posedge clk) begin
    if (ld_b) unit_b <= opnd_b;
    if (ld_c) unit_c <= opnd_c;
  end

  always_comb begin
    gate_res = '0;
    if (fn_sel[0]) gate_res = gate_res | (unit_b & unit_c);
    if (fn_sel[1]) gate_res = gate_res | (unit_b | unit_c);
    if (fn_sel[2]) gate_res = gate_res | (unit_b ^ unit_c);
    if (fn_sel[3]) gate_res = gate_res | ~unit_b;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] model_res(input logic [1:0] op, input logic [W-1:0] b,
                                             input logic [W-1:0] c);
    case (op)
      2'd0:    return b & c;
      2'd1:    return b | c;
      2'd2:    return b ^ c;
      default: return ~b;
    endcase
  endfunction

  // safety properties sampled every cycle out of reset
  always @(negedge clk) begin
    if (reset_n) begin
      check("fn_onehot0", 32'($onehot0(fn_sel)), 32'd1);
      check("fn_ld_overlap", 32'((|fn_sel) && (ld_b || ld_c)), 32'd0);
      check("busy_vs_ready", 32'(busy), 32'(!req_ready));
    end
  end

  // Called just after a negedge while the DUT is IDLE; returns with the response presented.
  task automatic send_and_check(input logic [1:0] op, input logic [W-1:0] b,
                                input logic [W-1:0] c, input int stall);
    logic [3:0] exp_fn;
    logic       exp_zero;
    logic       exp_sign;
    exp_fn = 4'b0001 << op;
    req_valid = 1'b1;
    req_op = op;
    req_b = b;
    req_c = c;
    rsp_ready = 1'b0;
    check("req_ready_idle", 32'(req_ready), 32'd1);
    exp_q.push_back(model_res(op, b, c));
    @(negedge clk);
    req_valid = 1'b0;
    req_b = W'($urandom);
    req_c = W'($urandom);
    check("ld_b_load", 32'(ld_b), 32'd1);
    check("ld_c_load", 32'(ld_c), 32'(op != 2'd3));
    check("opnd_b", 32'(opnd_b), 32'(b));
    if (op != 2'd3) check("opnd_c", 32'(opnd_c), 32'(c));
    check("busy_load", 32'(busy), 32'd1);
    for (int i = 0; i < SC; i++) begin
      @(negedge clk);
      check("fn_settle", 32'(fn_sel), 32'd0);
      check("ld_b_settle", 32'(ld_b), 32'd0);
      check("rsp_valid_settle", 32'(rsp_valid), 32'd0);
    end
    for (int i = 0; i < DC; i++) begin
      @(negedge clk);
      check("fn_drive", 32'(fn_sel), 32'(exp_fn));
      check("rsp_valid_drive", 32'(rsp_valid), 32'd0);
    end
`ifdef LOGIC_FLAGS_EN
    exp_zero = (exp_q[0] == '0);
    exp_sign = exp_q[0][W-1];
`else
    exp_zero = 1'b0;
    exp_sign = 1'b0;
`endif
    for (int s = 0; s <= stall; s++) begin
      @(negedge clk);
      check("rsp_valid", 32'(rsp_valid), 32'd1);
      check("rsp_data", 32'(rsp_data), 32'(exp_q[0]));
      check("rsp_zero", 32'(rsp_zero), 32'(exp_zero));
      check("rsp_sign", 32'(rsp_sign), 32'(exp_sign));
      check("fn_resp", 32'(fn_sel), 32'd0);
      check("req_ready_resp", 32'(req_ready), 32'd0);
      req_valid = ($urandom_range(0, 1) == 1);
    end
    req_valid = 1'b0;
    void'(exp_q.pop_front());
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    check("req_ready_back", 32'(req_ready), 32'd1);
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_fn_sel", 32'(fn_sel), 32'd0);
    check("rst_ld", 32'({ld_b, ld_c}), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // AND: F0 & 3C = 30
    send_and_check(2'd0, 8'hF0, 8'h3C, 0);
    release_rsp();
    // NOT of 00 = FF
    send_and_check(2'd3, 8'h00, 8'hA5, 1);
    release_rsp();
    // XOR of equal operands = 00
    send_and_check(2'd2, 8'h5A, 8'h5A, 0);
    release_rsp();

    // backpressure, then a request presented together with rsp_ready
    send_and_check(2'd1, 8'h81, 8'h10, 10);
    req_valid = 1'b1;
    req_op = 2'd0;
    req_b = 8'hCC;
    req_c = 8'h0F;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("bp_not_loaded_yet", 32'(ld_b), 32'd0);
    check("bp_rsp_dropped", 32'(rsp_valid), 32'd0);
    check("bp_ready_idle", 32'(req_ready), 32'd1);
    send_and_check(2'd0, 8'hCC, 8'h0F, 0);
    release_rsp();

    // async reset while driving
    req_valid = 1'b1;
    req_op = 2'd0;
    req_b = 8'hFF;
    req_c = 8'hFF;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (SC + 1) @(negedge clk);
    check("pre_rst_fn", 32'(fn_sel), 32'd1);
    reset_n = 1'b0;
    #1;
    check("arst_fn_sel", 32'(fn_sel), 32'd0);
    check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("arst_req_ready", 32'(req_ready), 32'd1);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_ld", 32'({ld_b, ld_c}), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (SC + DC + 2) begin
      @(negedge clk);
      check("no_partial_rsp", 32'(rsp_valid), 32'd0);
    end

    // randomized ops
    for (int n = 0; n < 24; n++) begin
      send_and_check(2'($urandom_range(0, 3)), W'($urandom), W'($urandom),
                     int'($urandom_range(0, 3)));
      release_rsp();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
